// File: rtl/bcd_convert_sequencer.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3) with start/busy/done handshake.
// The result register holds the last completed BCD word; out-of-range inputs saturate to all 9s.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; bcd_out/ovf hold the last result
//   SHIFT | one adjust+shift iteration per clk, IN_W iterations in total
module bcd_convert_sequencer #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [63:0]      LIMIT    = 64'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BCD_W-1:0] ALL_NINE = {DIGITS{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_nxt;
  logic [IN_W-1:0]    shift_nxt;

  // One add-3 per digit, then the combined {acc, shift} register moves left by one.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_nxt   = {acc_adj[BCD_W-2:0], shift_q[IN_W-1]};
    shift_nxt = {shift_q[IN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin;
          acc_d      = '0;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          ovf_pend_d = (64'(bin) > LIMIT);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_nxt;
        shift_d = shift_nxt;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          bcd_d   = ovf_pend_q ? ALL_NINE : acc_nxt;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Directed self-checking bench for bcd_convert_sequencer: reset, conversions, overflow,
// handshake (ignored start, back-to-back) and reset during a conversion.
module tb_bcd_convert_sequencer;

  logic        clk;
  logic        reset_p;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  int checks;
  int failures;
  logic [15:0] last_bcd;
  logic        last_ovf;

  bcd_convert_sequencer #(.IN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for busy to fall; reports busy samples seen and whether outputs held.
  task automatic run_until_done(input logic [15:0] hold_bcd, input logic hold_ovf,
                                output int busy_cnt, output bit stable, output bit timeout);
    busy_cnt = 0;
    stable   = 1'b1;
    timeout  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      busy_cnt++;
      if (bcd_out !== hold_bcd || ovf !== hold_ovf) stable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_por();
    #2;
    checks++;
    if ({busy, done, ovf, bcd_out} !== 19'h0) begin
      failures++;
      $display("FAIL reset_por busy=%b done=%b ovf=%b bcd=%h expected all zero", busy, done, ovf, bcd_out);
    end
    @(negedge clk); reset_p = 1'b0;
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
  endtask

  task automatic test_conv(input string name, input logic [13:0] v,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
    int busy_cnt;
    bit stable, timeout;
    @(negedge clk); bin = v; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    run_until_done(last_bcd, last_ovf, busy_cnt, stable, timeout);
    if (timeout) $display("FAIL %s timeout waiting for busy to drop", name);
    checks++;
    if (busy_cnt !== 14) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d exp=14", name, busy_cnt);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL %s outputs changed while busy (exp hold %h/%b)", name, last_bcd, last_ovf);
    end
    checks++;
    if (done !== 1'b1 || bcd_out !== exp_bcd || ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s result done=%b bcd=%h ovf=%b exp done=1 bcd=%h ovf=%b",
               name, done, bcd_out, ovf, exp_bcd, exp_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || bcd_out !== exp_bcd || ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s after_done done=%b bcd=%h ovf=%b exp done=0 bcd=%h ovf=%b",
               name, done, bcd_out, ovf, exp_bcd, exp_ovf);
    end
    last_bcd = exp_bcd;
    last_ovf = exp_ovf;
  endtask

  task automatic test_reset_idle();
    @(negedge clk); #2; reset_p = 1'b1;
    #1;
    checks++;
    if ({busy, done, ovf, bcd_out} !== 19'h0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b ovf=%b bcd=%h expected all zero", busy, done, ovf, bcd_out);
    end
    @(negedge clk); reset_p = 1'b0;
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
  endtask

  task automatic test_handshake();
    int busy_cnt;
    bit stable, timeout;
    @(negedge clk); bin = 14'd500; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); bin = 14'd77; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    run_until_done(last_bcd, last_ovf, busy_cnt, stable, timeout);
    if (timeout) $display("FAIL handshake_ignore timeout waiting for busy to drop");
    checks++;
    if (busy_cnt !== 11 || !stable) begin
      failures++;
      $display("FAIL handshake_ignore remaining_busy got=%0d exp=11 stable=%b", busy_cnt, stable);
    end
    checks++;
    if (done !== 1'b1 || bcd_out !== 16'h0500 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL handshake_ignore done=%b bcd=%h ovf=%b exp done=1 bcd=0500 ovf=0", done, bcd_out, ovf);
    end
    bin = 14'd31; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_accept done=%b busy=%b exp done=0 busy=1", done, busy);
    end
    run_until_done(16'h0500, 1'b0, busy_cnt, stable, timeout);
    if (timeout) $display("FAIL back_to_back timeout waiting for busy to drop");
    checks++;
    if (busy_cnt !== 14 || !stable) begin
      failures++;
      $display("FAIL back_to_back busy_cycles got=%0d exp=14 stable=%b", busy_cnt, stable);
    end
    checks++;
    if (done !== 1'b1 || bcd_out !== 16'h0031 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back done=%b bcd=%h ovf=%b exp done=1 bcd=0031 ovf=0", done, bcd_out, ovf);
    end
    @(posedge clk); #1;
    last_bcd = 16'h0031;
    last_ovf = 1'b0;
  endtask

  task automatic test_reset_midop();
    int done_seen;
    @(negedge clk); bin = 14'd8888; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; reset_p = 1'b1;
    #1;
    checks++;
    if ({busy, done, ovf, bcd_out} !== 19'h0) begin
      failures++;
      $display("FAIL reset_midop busy=%b done=%b ovf=%b bcd=%h expected all zero", busy, done, ovf, bcd_out);
    end
    @(negedge clk); reset_p = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0 || bcd_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_midop_quiet done_or_busy_cycles=%0d bcd=%h exp 0 and 0000", done_seen, bcd_out);
    end
    last_bcd = 16'h0000;
    last_ovf = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_p  = 1'b1;
    start    = 1'b0;
    bin      = '0;
    test_reset_por();
    test_conv("nominal_1234", 14'd1234, 16'h1234, 1'b0);
    test_reset_idle();
    test_conv("range_0", 14'd0, 16'h0000, 1'b0);
    test_conv("range_9999", 14'd9999, 16'h9999, 1'b0);
    test_conv("range_7", 14'd7, 16'h0007, 1'b0);
    test_conv("ovf_12345", 14'd12345, 16'h9999, 1'b1);
    test_conv("ovf_16383", 14'd16383, 16'h9999, 1'b1);
    test_conv("ovf_10000", 14'd10000, 16'h9999, 1'b1);
    test_conv("ovf_clear_42", 14'd42, 16'h0042, 1'b0);
    test_handshake();
    test_reset_midop();
    test_conv("after_reset_2024", 14'd2024, 16'h2024, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
